// File: rtl/mant_mul_pkg.sv
// Shared defaults, product width and FSM encoding for the sequential mantissa multiplier.
package mant_mul_pkg;
  localparam int unsigned A_W_DEF    = 46;
  localparam int unsigned DIG_W_DEF  = 7;
  localparam int unsigned NCHUNK_DEF = 7;
  localparam int unsigned PROD_W_DEF = A_W_DEF + DIG_W_DEF * NCHUNK_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_WAIT,
    ST_ACC,
    ST_DONE
  } state_t;
endpackage

// File: rtl/mant_mul_acc.sv
// Shift-add accumulator: adds one chunk product at digit position shift_i per enabled cycle.
// sum_o already includes the addend of the current enabled cycle, so the caller can capture the final sum without an extra cycle.
module mant_mul_acc #(
  parameter int unsigned A_W   = 46,
  parameter int unsigned DIG_W = 7,
  parameter int unsigned P_W   = 95,
  parameter int unsigned K_W   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_i,
  input  logic                   add_en_i,
  input  logic [K_W-1:0]         shift_i,
  input  logic [A_W+DIG_W-1:0]   chunk_i,
  output logic [P_W-1:0]         sum_o
);
  logic [P_W-1:0] sum_q;
  logic [P_W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q + (P_W'(chunk_i) << (DIG_W * shift_i));
  end

  assign sum_o = add_en_i ? sum_d : sum_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      sum_q <= '0;
    end else if (add_en_i) begin
      sum_q <= sum_d;
    end
  end
endmodule

// File: rtl/mant_mul_seq.sv
// Sequential unsigned multiplier issuing one multiplier digit at a time to an external chunk core; start is taken only in IDLE.
// Latency: per issued chunk 1 (CLR) + core + 1 (ACC), plus 1 DONE cycle. Build option ZERO_DIGIT_SKIP_EN skips zero digits.
module mant_mul_seq
  import mant_mul_pkg::*;
#(
  parameter int unsigned A_W    = A_W_DEF,
  parameter int unsigned DIG_W  = DIG_W_DEF,
  parameter int unsigned NCHUNK = NCHUNK_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [A_W-1:0]                a,
  input  logic [DIG_W*NCHUNK-1:0]       b,
  output logic                          busy,
  output logic                          done,
  output logic [A_W+DIG_W*NCHUNK-1:0]   prod,
  output logic                          cm_rst,
  output logic [A_W:0]                  cm_x,
  output logic [DIG_W:0]                cm_y,
  input  logic [A_W+DIG_W-1:0]          cm_out,
  input  logic                          cm_ready
);
  localparam int unsigned B_W = DIG_W * NCHUNK;
  localparam int unsigned P_W = A_W + B_W;
  localparam int unsigned K_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t           state_q;
  logic [K_W-1:0]   k_q;
  logic [B_W-1:0]   b_q;
  logic             wait_first_q;
  logic             busy_q;
  logic             done_q;
  logic [P_W-1:0]   prod_q;
  logic             cm_rst_q;
  logic [A_W:0]     cm_x_q;
  logic [DIG_W:0]   cm_y_q;
  logic [P_W-1:0]   acc_sum;

  logic             first_vld;
  logic [K_W-1:0]   first_k;
  logic             next_vld;
  logic [K_W-1:0]   next_k;

  function automatic logic [DIG_W-1:0] digit_at(input logic [B_W-1:0] bv, input logic [K_W-1:0] kk);
    return DIG_W'(bv >> (DIG_W * kk));
  endfunction

`ifdef ZERO_DIGIT_SKIP_EN
  // Scan downwards so the lowest qualifying digit index wins.
  always_comb begin
    first_vld = 1'b0;
    first_k   = '0;
    next_vld  = 1'b0;
    next_k    = '0;
    for (int i = int'(NCHUNK) - 1; i >= 0; i--) begin
      if (digit_at(b, K_W'(i)) != '0) begin
        first_vld = 1'b1;
        first_k   = K_W'(i);
      end
      if (i > int'(k_q) && digit_at(b_q, K_W'(i)) != '0) begin
        next_vld = 1'b1;
        next_k   = K_W'(i);
      end
    end
  end
`else
  always_comb begin
    first_vld = 1'b1;
    first_k   = '0;
    next_vld  = (int'(k_q) + 1) < int'(NCHUNK);
    next_k    = k_q + K_W'(1);
  end
`endif

  mant_mul_acc #(
    .A_W   (A_W),
    .DIG_W (DIG_W),
    .P_W   (P_W),
    .K_W   (K_W)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q == ST_IDLE && start),
    .add_en_i (state_q == ST_ACC),
    .shift_i  (k_q),
    .chunk_i  (cm_out),
    .sum_o    (acc_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      b_q          <= '0;
      wait_first_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      prod_q       <= '0;
      cm_rst_q     <= 1'b1;
      cm_x_q       <= '0;
      cm_y_q       <= '0;
    end else begin
      cm_rst_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            b_q    <= b;
            cm_x_q <= {1'b0, a};
            k_q    <= first_k;
            if (first_vld) begin
              state_q  <= ST_CLR;
              busy_q   <= 1'b1;
              cm_rst_q <= 1'b1;
              cm_y_q   <= {1'b0, digit_at(b, first_k)};
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              prod_q  <= '0;
            end
          end
        end
        ST_CLR: begin
          state_q      <= ST_WAIT;
          wait_first_q <= 1'b1;
        end
        // A ready left over from the previous chunk may still be visible in the first WAIT cycle.
        ST_WAIT: begin
          wait_first_q <= 1'b0;
          if (!wait_first_q && cm_ready) begin
            state_q <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (next_vld) begin
            state_q  <= ST_CLR;
            k_q      <= next_k;
            cm_rst_q <= 1'b1;
            cm_y_q   <= {1'b0, digit_at(b_q, next_k)};
          end else begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            prod_q  <= acc_sum;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign prod   = prod_q;
  assign cm_rst = cm_rst_q;
  assign cm_x   = cm_x_q;
  assign cm_y   = cm_y_q;
endmodule

// File: tb/tb_mant_mul_seq.sv
// Bench for mant_mul_seq with a behavioural chunk core; expected products go through a scoreboard queue.
module tb_mant_mul_seq;
  localparam int A_W    = 46;
  localparam int DIG_W  = 7;
  localparam int NCHUNK = 7;
  localparam int B_W    = DIG_W * NCHUNK;
  localparam int P_W    = A_W + B_W;
  localparam int CORE_L = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [A_W-1:0]       a;
  logic [B_W-1:0]       b;
  logic                 busy;
  logic                 done;
  logic [P_W-1:0]       prod;
  logic                 cm_rst;
  logic [A_W:0]         cm_x;
  logic [DIG_W:0]       cm_y;
  logic [A_W+DIG_W-1:0] cm_out;
  logic                 cm_ready;

  int errs = 0;
  int checks = 0;
  int busy_cycles = 0;
  int rst_pulses = 0;
  logic [P_W-1:0] sb[$];

  mant_mul_seq #(.A_W(A_W), .DIG_W(DIG_W), .NCHUNK(NCHUNK)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .prod(prod),
    .cm_rst(cm_rst), .cm_x(cm_x), .cm_y(cm_y),
    .cm_out(cm_out), .cm_ready(cm_ready)
  );

  always #5 clk = ~clk;

  // Chunk core: result appears CORE_L edges after the restart strobe, ready sticky until the next strobe.
  int core_cnt;
  always @(posedge clk) begin
    if (reset) begin
      core_cnt <= 0;
      cm_ready <= 1'b0;
      cm_out   <= '0;
    end else if (cm_rst) begin
      core_cnt <= CORE_L;
      cm_ready <= 1'b0;
      cm_out   <= {{DIG_W{1'b0}}, cm_x[A_W-1:0]} * {{A_W{1'b0}}, cm_y[DIG_W-1:0]};
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) cm_ready <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cycles++;
      if (cm_rst && busy) rst_pulses++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          logic [P_W-1:0] e;
          e = sb.pop_front();
          chk("prod", prod, e);
        end
      end
    end
  end

  function automatic int n_chunks(input logic [B_W-1:0] bv);
    int n;
    n = NCHUNK;
`ifdef ZERO_DIGIT_SKIP_EN
    n = 0;
    for (int i = 0; i < NCHUNK; i++) begin
      logic [B_W-1:0] t;
      t = bv >> (i * DIG_W);
      if (t[DIG_W-1:0] != '0) n++;
    end
`endif
    return n;
  endfunction

  function automatic logic [P_W-1:0] model(input logic [A_W-1:0] av, input logic [B_W-1:0] bv);
    logic [P_W-1:0] ea;
    logic [P_W-1:0] eb;
    ea = P_W'(av);
    eb = P_W'(bv);
    return ea * eb;
  endfunction

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic run_op(input logic [A_W-1:0] av, input logic [B_W-1:0] bv, input string tag);
    int n;
    busy_cycles = 0;
    rst_pulses  = 0;
    a = av;
    b = bv;
    start = 1'b1;
    sb.push_back(model(av, bv));
    @(negedge clk);
    start = 1'b0;
    wait_done(tag);
    n = n_chunks(bv);
    chk({tag, "_latency"}, busy_cycles, n * (CORE_L + 3));
    chk({tag, "_cm_rst_pulses"}, rst_pulses, n);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_single"}, done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    logic [A_W-1:0] ones_a;
    logic [B_W-1:0] ones_b;
    logic [B_W-1:0] b_hi;
    logic [A_W-1:0] ra;
    logic [B_W-1:0] rb;
    int n;
    bit got_done;

    ones_a = '1;
    ones_b = '1;
    b_hi   = {7'h7F, 42'd0};
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prod", prod, 0);
    chk("rst_cm_rst", cm_rst, 1);
    chk("rst_cm_x", cm_x, 0);
    chk("rst_cm_y", cm_y, 0);
    reset = 1'b0;
    @(negedge clk);

    run_op(46'd1, 49'd1, "one_x_one");
    run_op(ones_a, ones_b, "all_ones");
    run_op(46'd3, b_hi, "top_digit");
    run_op('0, ones_b, "a_zero");
    run_op(46'h1234_5678_9AB, '0, "b_zero");
    run_op(46'd12345, {7'd0, 7'h55, 7'd0, 7'd0, 7'h01, 7'd0, 7'h7F}, "sparse");
    for (int i = 0; i < 4; i++) begin
      ra = A_W'({$urandom(), $urandom()});
      rb = B_W'({$urandom(), $urandom()});
      run_op(ra, rb, $sformatf("rand%0d", i));
    end

    // Second start two cycles into an operation must not disturb it.
    a = 46'h2AB_CDEF_0123;
    b = 49'h1_2345_6789_ABCD;
    start = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 46'd999;
    b = 49'd777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_cm_x", cm_x, {1'b0, 46'h2AB_CDEF_0123});
    wait_done("busy_start");
    @(negedge clk);

    // Start held through DONE: only the following IDLE sample may be taken.
    a = 46'd11;
    b = 49'd13;
    start = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    wait_done("pre_done_start");
    a = 46'd1000;
    b = 49'd3;
    start = 1'b1;
    @(negedge clk);
    a = 46'd21;
    b = 49'd17;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    wait_done("idle_after_done");
    @(negedge clk);

    // Abort with reset in the WAIT state of chunk 3.
    a = 46'h3FF_FFFF;
    b = ones_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = (cm_rst && busy) ? 1 : 0;
    for (int i = 0; i < 2000 && n < 4; i++) begin
      @(negedge clk);
      if (cm_rst && busy) n++;
    end
    chk("abort_reached_chunk3", n, 4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    reset = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    chk("abort_no_done", got_done, 0);
    run_op(46'd5, 49'd7, "after_abort");
    chk("after_abort_prod", prod, 35);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
